// File: rtl/mpc_arb_pkg.sv
// Shared arbiter definitions: default port count, select width and FSM state encoding.
package mpc_arb_pkg;

    localparam int PORT_NUM_DFLT = 16;
    localparam int PORT_W        = $clog2(PORT_NUM_DFLT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/oport_arb_rr_pick.sv
// Combinational round-robin picker (module rr_pick): first set request bit at or above ptr, with wrap.
module rr_pick
    import mpc_arb_pkg::*;
#(
    parameter int N = PORT_NUM_DFLT,
    parameter int W = PORT_W
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [W-1:0]   w_off;
    logic [W:0]     w_sum;

    // Doubling the vector makes a plain right shift behave as a rotate, so bit 0 is i_req[i_ptr].
    assign w_dbl = {i_req, i_req};
    assign w_rot = N'(w_dbl >> i_ptr);

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = W'(i);
            end
        end
    end

    assign w_sum    = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx    = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
    assign o_found  = |i_req;
    assign o_onehot = o_found ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/oport_arb.sv
// Per-output-port round-robin arbiter with grant hold until finish or withdrawal.
// Optional watchdog release is compiled in with the ARB_TIMEOUT_EN macro.
module oport_arb
    import mpc_arb_pkg::*;
#(
    parameter  int PORT_NUM    = PORT_NUM_DFLT,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int SEL_W       = $clog2(PORT_NUM)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PORT_NUM-1:0] i_req,
    input  logic [PORT_NUM-1:0] i_finish,
    input  logic                i_oport_ready,
    output logic [PORT_NUM-1:0] o_resp,
    output logic [SEL_W-1:0]    o_sel,
    output logic                o_grant_vld,
    output logic                o_ready,
    output logic                o_timeout
);

    arb_state_t          r_state;
    arb_state_t          w_nxt;
    logic [PORT_NUM-1:0] r_resp;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic                r_gvld;

    logic [PORT_NUM-1:0] w_onehot;
    logic [SEL_W-1:0]    w_idx;
    logic                w_found;
    logic                w_issue;
    logic                w_fin;
    logic                w_hold;
    logic                w_tfire;
    logic                w_rel;

    rr_pick #(
        .N (PORT_NUM),
        .W (SEL_W)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_found  (w_found)
    );

    assign w_issue = (r_state == IDLE) && w_found && i_oport_ready;
    assign w_fin   = i_finish[r_sel];
    assign w_hold  = i_req[r_sel];
    assign w_rel   = (r_state == GRANT) && (w_fin || !w_hold || w_tfire);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_nxt = GRANT;
            GRANT:   if (w_rel)   w_nxt = REL;
            REL:     w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_resp  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_gvld  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_gvld  <= 1'b0;
            if (w_issue) begin
                r_resp <= w_onehot;
                r_sel  <= w_idx;
                r_gvld <= 1'b1;
            end else if (w_rel) begin
                r_resp <= '0;
                r_ptr  <= (r_sel == SEL_W'(PORT_NUM - 1)) ? '0 : r_sel + 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_tmo;

    assign w_tfire = (r_cnt == 16'(TIMEOUT_CYC - 1));

    // The pulse lands in the REL cycle and only when the watchdog alone caused the release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= (r_state == GRANT) && w_tfire && w_hold && !w_fin;
            if (w_issue) begin
                r_cnt <= '0;
            end else if (r_state == GRANT) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_timeout = r_tmo;
`else
    assign w_tfire   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_resp      = r_resp;
    assign o_sel       = r_sel;
    assign o_grant_vld = r_gvld;
    assign o_ready     = (r_state == IDLE);

endmodule

// File: tb/tb_oport_arb.sv
// Bench for oport_arb: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_oport_arb;

    localparam int N = 16;
`ifdef ARB_TIMEOUT_EN
    localparam int TCYC  = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TCYC  = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  fin = '0;
    logic          ordy = 1'b0;
    logic [N-1:0]  o_resp;
    logic [3:0]    o_sel;
    logic          o_grant_vld;
    logic          o_ready;
    logic          o_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 = waiting, 1 = holding grant, 2 = cooldown cycle.
    int m_phase = 0;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit e_gvld  = 1'b0;
    bit e_tmo   = 1'b0;

    oport_arb #(
        .PORT_NUM    (N),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_finish      (fin),
        .i_oport_ready (ordy),
        .o_resp        (o_resp),
        .o_sel         (o_sel),
        .o_grant_vld   (o_grant_vld),
        .o_ready       (o_ready),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        bit f, w, t;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
                e_gvld = 1'b0; e_tmo = 1'b0;
            end else begin
                e_gvld = 1'b0;
                e_tmo  = 1'b0;
                case (m_phase)
                    0: if (req != 0 && ordy) begin
                        for (int k = 0; k < N; k++) begin
                            if (req[(m_ptr + k) % N]) begin
                                m_sel = (m_ptr + k) % N;
                                break;
                            end
                        end
                        m_phase = 1;
                        m_cnt   = 0;
                        e_gvld  = 1'b1;
                    end
                    1: begin
                        f = fin[m_sel];
                        w = !req[m_sel];
                        t = TO_EN && (m_cnt == TCYC - 1);
                        if (f || w || t) begin
                            m_phase = 2;
                            m_ptr   = (m_sel + 1) % N;
                            e_tmo   = t && !f && !w;
                        end else begin
                            m_cnt++;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("m_resp",  32'(o_resp), (m_phase == 1) ? (32'd1 << m_sel) : 32'd0);
            check("m_sel",   32'(o_sel), 32'(m_sel));
            check("m_gvld",  32'(o_grant_vld), 32'(e_gvld));
            check("m_ready", 32'(o_ready), 32'(m_phase == 0));
            check("m_tmo",   32'(o_timeout), 32'(e_tmo));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        fin   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (o_grant_vld) seen = 1'b1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check(name, 32'(o_sel), 32'(exp));
            check({name, "_resp"}, 32'(o_resp), 32'd1 << exp);
        end
    endtask

    task automatic pulse_fin(input int idx);
        fin = N'(1) << idx;
        @(negedge clk);
        fin = '0;
    endtask

    initial begin : stim
        int hold_cnt;
        bit tmo_seen;
        int r;
        repeat (2) @(negedge clk);
        check("rst_resp",  32'(o_resp), 32'd0);
        check("rst_sel",   32'(o_sel), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_gvld",  32'(o_grant_vld), 32'd0);
        check("rst_tmo",   32'(o_timeout), 32'd0);
        rst_n = 1'b1;

        // Single grant and finish
        @(negedge clk);
        req = 16'h0001; ordy = 1'b1;
        @(negedge clk);
        check("t1_resp", 32'(o_resp), 32'h0001);
        check("t1_sel",  32'(o_sel), 32'd0);
        check("t1_gvld", 32'(o_grant_vld), 32'd1);
        @(negedge clk);
        check("t1_gvld_pulse", 32'(o_grant_vld), 32'd0);
        fin = 16'h0001;
        @(negedge clk);
        fin = '0; req = '0;
        check("t1_rel_resp",  32'(o_resp), 32'd0);
        check("t1_rel_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        check("t1_idle_ready", 32'(o_ready), 32'd1);

        // Fairness and wrap
        do_reset();
        req = 16'h8101; ordy = 1'b1;
        wait_grant(0, "t2_g0");  pulse_fin(0);
        wait_grant(8, "t2_g8");  pulse_fin(8);
        wait_grant(15, "t2_g15"); pulse_fin(15);
        wait_grant(0, "t2_gw");  pulse_fin(0);
        req = '0;

        // Finish from a non-granted port is ignored
        do_reset();
        req = 16'h0008;
        wait_grant(3, "t3_g3");
        fin = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fin = '0;
            check("t3_hold", 32'(o_resp), 32'h0008);
        end
        pulse_fin(3);
        req = '0;

        // Output port not ready blocks grants
        do_reset();
        req = 16'hFFFF; ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_nogrant", 32'(o_resp), 32'd0);
            check("t4_ready",   32'(o_ready), 32'd1);
        end
        ordy = 1'b1;
        wait_grant(0, "t4_g0");
        req = '0;
        @(negedge clk);
        check("t4_withdraw", 32'(o_resp), 32'd0);

        // Withdrawal moves the pointer past the withdrawn port
        do_reset();
        req = 16'h0020;
        wait_grant(5, "t5_g5");
        req = 16'h0041;
        @(negedge clk);
        check("t5_rel_resp",  32'(o_resp), 32'd0);
        check("t5_rel_ready", 32'(o_ready), 32'd0);
        wait_grant(6, "t5_g6");
        pulse_fin(6);
        req = '0;

        // Watchdog release, or indefinite hold without it
        do_reset();
        req = 16'h0004;
        wait_grant(2, "t6_g2");
`ifdef ARB_TIMEOUT_EN
        hold_cnt = 1;
        tmo_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_resp == 0) begin
                tmo_seen = o_timeout;
                break;
            end
            hold_cnt++;
        end
        check("t6_hold_cycles", 32'(hold_cnt), 32'(TCYC));
        check("t6_tmo_pulse",   32'(tmo_seen), 32'd1);
        req = '0;
        @(negedge clk);
        check("t6_tmo_once", 32'(o_timeout), 32'd0);
`else
        repeat (40) @(negedge clk);
        check("t6_held", 32'(o_resp), 32'h0004);
        check("t6_no_tmo", 32'(o_timeout), 32'd0);
        req = '0;
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 16'h0002;
        wait_grant(1, "t7_g1");
        pulse_fin(1);
        req = 16'h0401;
        wait_grant(10, "t7_g10");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_resp",  32'(o_resp), 32'd0);
        check("t7_rst_ready", 32'(o_ready), 32'd1);
        check("t7_rst_sel",   32'(o_sel), 32'd0);
        check("t7_rst_gvld",  32'(o_grant_vld), 32'd0);
        check("t7_rst_tmo",   32'(o_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(0, "t7_ptr0");
        req = '0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = N'($urandom) & N'($urandom);
            fin = '0;
            r = $urandom_range(0, 11);
            if (r < 2)       fin = N'(1) << m_sel;
            else if (r < 4)  fin = N'(1) << $urandom_range(0, N - 1);
            else if (r == 4) fin = N'($urandom);
            else if (r == 5) req[m_sel] = 1'b0;
            ordy = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
